// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO slave beats into one master word,
// closing a word early on tlast. Single output register, one cycle latency.
module axis_upsizer #(
  parameter int S_TDATA_WIDTH = 64,
  parameter int RATIO         = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [S_TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [S_TDATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [S_TDATA_WIDTH*RATIO-1:0]     m_axis_tdata,
  output logic [S_TDATA_WIDTH*RATIO/8-1:0]   m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tuser
);

  localparam int M_TDATA_WIDTH = S_TDATA_WIDTH * RATIO;
  localparam int S_KEEP_W      = S_TDATA_WIDTH / 8;
  localparam int M_KEEP_W      = M_TDATA_WIDTH / 8;
  localparam int IDX_W         = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [M_TDATA_WIDTH-1:0] acc_data_q, acc_data_d, merged_data;
  logic [M_KEEP_W-1:0]      acc_keep_q, acc_keep_d, merged_keep;
  logic                     acc_user_q, acc_user_d;
  logic                     m_valid_q, m_valid_d;
  logic [M_TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [M_KEEP_W-1:0]      m_keep_q, m_keep_d;
  logic                     m_last_q, m_last_d;
  logic                     m_user_q, m_user_d;
  logic                     accept, complete;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && ((idx_q == LAST_IDX) || s_axis_tlast);

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;

  // Lanes above idx are still zero in the accumulator, so an early tlast
  // leaves the unfilled upper lanes cleared without extra masking.
  always_comb begin
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int l = 0; l < RATIO; l++) begin
      if (idx_q == IDX_W'(l)) begin
        merged_data[l*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_axis_tdata;
        merged_keep[l*S_KEEP_W +: S_KEEP_W]           = s_axis_tkeep;
      end
    end
  end

  always_comb begin
    idx_d      = idx_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_user_d = acc_user_q;
    m_valid_d  = m_valid_q && !m_axis_tready;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    if (accept) begin
      if (complete) begin
        idx_d      = '0;
        acc_data_d = '0;
        acc_keep_d = '0;
        acc_user_d = 1'b0;
        m_valid_d  = 1'b1;
        m_data_d   = merged_data;
        m_keep_d   = merged_keep;
        m_last_d   = s_axis_tlast;
        m_user_d   = acc_user_q | s_axis_tuser;
      end else begin
        idx_d      = idx_q + IDX_W'(1);
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
        acc_user_d = acc_user_q | s_axis_tuser;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_user_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      acc_user_q <= acc_user_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
    end
  end

endmodule

// File: doc/axis_upsizer.md
AXIS_UPSIZER -- requirements
Module: axis_upsizer

Interface
REQ-001 SHALL have parameter S_TDATA_WIDTH, default 64, slave tdata width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter RATIO, default 2, number of slave beats packed per master beat; must be at least 2.
REQ-003 SHALL derive M_TDATA_WIDTH = S_TDATA_WIDTH*RATIO internally; it SHALL NOT be an overridable parameter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port s_axis_tvalid, input, 1, slave beat valid.
REQ-008 SHALL have port s_axis_tready, output, 1, slave beat accepted.
REQ-009 SHALL have port s_axis_tdata, input, S_TDATA_WIDTH, slave data.
REQ-010 SHALL have port s_axis_tkeep, input, S_TDATA_WIDTH/8, slave byte enables.
REQ-011 SHALL have port s_axis_tlast, input, 1, slave packet end.
REQ-012 SHALL have port s_axis_tuser, input, 1, slave sideband flag.
REQ-013 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, M_TDATA_WIDTH), m_axis_tkeep (output, M_TDATA_WIDTH/8), m_axis_tlast (output, 1) and m_axis_tuser (output, 1), mirroring the slave signals.

Function
REQ-014 SHALL count a slave transfer only when s_axis_tvalid and s_axis_tready are both 1 on a rising edge.
REQ-015 SHALL keep a lane index idx in 0..RATIO-1; an accepted beat SHALL go to tdata bits [idx*S_TDATA_WIDTH +: S_TDATA_WIDTH] and to the matching tkeep lane (lane 0 = LSBs).
REQ-016 SHALL treat a beat as completing when idx==RATIO-1 or s_axis_tlast==1.
REQ-017 A non-completing beat SHALL increment idx; a completing beat SHALL reset idx to 0.
REQ-018 On a completing beat, the output register SHALL load the accumulated lanes plus the current beat.
REQ-019 In that load, unfilled higher lanes SHALL have tdata=0 and tkeep=0, m_axis_tlast SHALL equal s_axis_tlast, and m_axis_tuser SHALL be the OR of tuser over all beats packed into that word.
REQ-020 m_axis_tvalid SHALL rise on the cycle after the completing beat is accepted (latency 1 cycle).
REQ-021 s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready), so input runs at full rate whenever the output drains.
REQ-022 While m_axis_tvalid==1 and m_axis_tready==0, all m_axis_* outputs SHALL stay stable.
REQ-023 m_axis_tvalid SHALL clear after the master handshake unless a new completing beat is accepted in the same cycle, in which case it SHALL stay 1 with new contents.
REQ-024 tkeep values SHALL pass through unchanged, including sparse tkeep on non-last beats; no checking.
REQ-025 The accumulator SHALL be cleared to 0 after each completing beat, so stale lanes never leak into a later word.

Reset
REQ-026 While rst==1: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, idx=0 and accumulator=0.
REQ-027 Reset asserted mid-packet SHALL discard the partial word; the first beat accepted after reset SHALL map to lane 0.
REQ-028 s_axis_tready SHALL be 1 in the first cycle after rst deasserts.

Verification (S_TDATA_WIDTH=64, RATIO=2)
REQ-029 Scenario: beats 64'h1111111111111111, then 64'h2222222222222222 with tlast and m_axis_tready=1 -> one word 128'h2222222222222222_1111111111111111, tkeep 16'hFFFF, tlast 1, valid one cycle after beat 2.
REQ-030 Scenario: single beat 64'hAABBCCDD, tkeep 8'h0F, tlast 1 -> tdata 128'h...0000_00000000AABBCCDD (upper lane zero), tkeep 16'h000F, tlast 1.
REQ-031 Scenario: output full, m_axis_tready=0 for 5 cycles -> s_axis_tready 0 and m_axis_tdata stable throughout; after release all words arrive in order with no loss or duplication.
REQ-032 Scenario: 8 back-to-back beats, tlast on beat 8, m_axis_tready=1 -> 4 words, s_axis_tready stays 1 every cycle, tlast only on word 4.
REQ-033 Scenario: rst pulsed after beat 1 of a packet -> m_axis_tvalid 0; next two beats form a clean word with the first in lane 0.
REQ-034 Scenario: tuser=1 on beat 2 only -> m_axis_tuser=1 for that word and 0 for the following word.
